// File: rtl/dm_bytelane.sv
// dm_bytelane: word-organised data memory for the MEM stage.
// Byte/half/word loads and stores with sign/zero extension, a valid/ready
// request port, a registered one-cycle load response, fault reporting and a
// hardware zero sweep after reset or on request.
// Optional feature: define DM_TRACE_EN to print a trace line for every
// non-faulting store (full merged word). Undefined by default.
module dm_bytelane #(
  parameter int unsigned DEPTH = 3072,
  parameter int unsigned IW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_uns,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic        busy
);

  localparam int unsigned AW = 30;

  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_RANGE    = 2'd2;
  localparam logic [1:0] EXC_SIZE     = 2'd3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          exc_valid_q, exc_valid_d;
  logic [1:0]    exc_code_q, exc_code_d;

  logic [31:0]   mem [DEPTH];

  logic          acc_c;
  logic [AW-1:0] word_idx_c;
  logic [IW-1:0] idx_c;
  logic [1:0]    lane_c;
  logic          fault_c;
  logic [1:0]    fault_code_c;
  logic [31:0]   rd_word_c;
  logic [31:0]   shifted_c;
  logic [31:0]   load_ext_c;
  logic [3:0]    be_c;
  logic [31:0]   wdata_rep_c;
  logic [31:0]   merged_c;
  logic          st_ok_c;
  logic          mem_we_c;
  logic [IW-1:0] mem_idx_c;
  logic [31:0]   mem_wdata_c;

  // Request decode: fault classification, lane select, load extension, store merge
  always_comb begin
    acc_c        = req_valid && (state_q == ST_IDLE);
    word_idx_c   = req_addr[31:2];
    idx_c        = word_idx_c[IW-1:0];
    lane_c       = req_addr[1:0];
    fault_c      = 1'b0;
    fault_code_c = 2'd0;
    if (req_size == 2'd3) begin
      fault_c      = 1'b1;
      fault_code_c = EXC_SIZE;
    end else if ((req_size == 2'd1 && lane_c[0]) ||
                 (req_size == 2'd2 && lane_c != 2'd0)) begin
      fault_c      = 1'b1;
      fault_code_c = EXC_MISALIGN;
    end else if (word_idx_c >= AW'(DEPTH)) begin
      fault_c      = 1'b1;
      fault_code_c = EXC_RANGE;
    end

    rd_word_c = mem[idx_c];
    shifted_c = rd_word_c >> {lane_c, 3'b000};
    case (req_size)
      2'd0:    load_ext_c = req_uns ? {24'd0, shifted_c[7:0]}
                                    : {{24{shifted_c[7]}}, shifted_c[7:0]};
      2'd1:    load_ext_c = req_uns ? {16'd0, shifted_c[15:0]}
                                    : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: load_ext_c = rd_word_c;
    endcase

    case (req_size)
      2'd0:    begin be_c = 4'b0001 << lane_c; wdata_rep_c = {4{req_wdata[7:0]}};  end
      2'd1:    begin be_c = 4'b0011 << lane_c; wdata_rep_c = {2{req_wdata[15:0]}}; end
      default: begin be_c = 4'b1111;           wdata_rep_c = req_wdata;            end
    endcase
    for (int b = 0; b < 4; b++) begin
      merged_c[8*b +: 8] = be_c[b] ? wdata_rep_c[8*b +: 8] : rd_word_c[8*b +: 8];
    end

    st_ok_c = acc_c && req_we && !fault_c;
  end

  // Array write port: sweep writes in CLEAR, merged store data in IDLE
  always_comb begin
    mem_we_c    = 1'b0;
    mem_idx_c   = idx_c;
    mem_wdata_c = merged_c;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we_c    = 1'b1;
        mem_idx_c   = clr_idx_q;
        mem_wdata_c = 32'd0;
      end else if (st_ok_c) begin
        mem_we_c = 1'b1;
      end
    end
  end

  // Storage array; contents are deliberately not reset (the sweep zeroes them)
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_idx_c] <= mem_wdata_c;
  end

  // Next-state, sweep index and registered response/fault outputs
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    exc_valid_d = 1'b0;
    exc_code_d  = exc_code_q;

    case (state_q)
      ST_CLEAR: begin
        if (clr_idx_q == IW'(DEPTH - 1)) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IW'(1);
        end
      end
      ST_IDLE: begin
        if (clr_start) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    if (acc_c) begin
      if (fault_c) begin
        exc_valid_d = 1'b1;
        exc_code_d  = fault_code_c;
      end else if (!req_we) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_ext_c;
      end
    end

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_CLEAR);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;

`ifdef DM_TRACE_EN
  // Store trace: one line per committed store showing the full merged word
  always @(posedge clk) begin
    if (!reset && st_ok_c)
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged_c);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Scoreboard bench for dm_bytelane: directed requests push expected responses,
// a negedge monitor pops and compares them (value, kind and arrival cycle).
module tb_dm_bytelane;

  localparam int unsigned DEPTH = 3072;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr_start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] req_pc = 32'h0040_0000;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic        busy;

  dm_bytelane #(.DEPTH(DEPTH), .IW(12)) dut (
    .clk(clk), .reset(reset), .clr_start(clr_start),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_exc;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response/fault pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && (rsp_valid || exc_valid)) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_out: rsp_valid=%0b exc_valid=%0b rdata=%h code=%0d expected none",
                 rsp_valid, exc_valid, rsp_rdata, exc_code);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_kind", {31'd0, exc_valid}, {31'd0, e.is_exc});
        check("out_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_exc) check("exc_code", {30'd0, exc_code}, e.data);
        else          check("rsp_rdata", rsp_rdata, e.data);
      end
    end
  end

  // Wait (bounded) for req_ready; returns cycles waited
  task automatic wait_ready(input string name, output int n);
    n = 0;
    while (!req_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check(name, 32'(req_ready), 32'd1);
  endtask

  // Issue one request; push the expected response (if any) before the accepting edge
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic clr,
                      input bit has_out, input bit is_exc, input logic [31:0] exp_data,
                      output int acc_cyc);
    int w;
    exp_t e;
    wait_ready("ready_timeout", w);
    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata; clr_start = clr;
    if (has_out) begin
      e.is_exc = is_exc; e.data = exp_data; e.cyc = cyc + 1;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0; clr_start = 1'b0;
  endtask

  task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int c;
    send(1'b1, size, 1'b0, addr, wdata, 1'b0, 1'b0, 1'b0, 32'd0, c);
  endtask

  task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                    input logic [31:0] exp);
    int c;
    send(1'b0, size, uns, addr, 32'd0, 1'b0, 1'b1, 1'b0, exp, c);
  endtask

  task automatic flt(input logic we, input logic [1:0] size, input logic [31:0] addr,
                     input logic [1:0] code);
    int c;
    send(we, size, 1'b0, addr, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, {30'd0, code}, c);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c1, c2;

    // 1. reset values, sweep length, first load
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_exc_valid", 32'(exc_valid), 32'd0);
    check("rst_exc_code", 32'(exc_code), 32'd0);
    @(negedge clk) reset = 1'b0;
    n = 0;
    while (!req_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1000) check("sweep_busy_mid", 32'(busy), 32'd1);
    end
    check("sweep_len", 32'(n), 32'(DEPTH));
    check("idle_busy", 32'(busy), 32'd0);
    ld(2'd2, 1'b0, 32'h0000_0000, 32'h0000_0000);

    // 2. lane merge and extension
    st(2'd2, 32'h10, 32'h8899_AABB);
    st(2'd0, 32'h11, 32'h0000_007F);
    ld(2'd2, 1'b0, 32'h10, 32'h8899_7FBB);
    ld(2'd0, 1'b0, 32'h13, 32'hFFFF_FF88);
    ld(2'd0, 1'b1, 32'h13, 32'h0000_0088);
    ld(2'd1, 1'b0, 32'h12, 32'hFFFF_8899);
    ld(2'd1, 1'b1, 32'h12, 32'h0000_8899);
    ld(2'd1, 1'b0, 32'h10, 32'h0000_7FBB);
    ld(2'd0, 1'b0, 32'h11, 32'h0000_007F);
    ld(2'd2, 1'b1, 32'h10, 32'h8899_7FBB);
    st(2'd1, 32'h16, 32'h0000_C3A5);
    ld(2'd2, 1'b0, 32'h14, 32'hC3A5_0000);

    // 3. faults leave memory untouched; priority size > misalign > range
    flt(1'b1, 2'd1, 32'h11, 2'd1);
    ld(2'd2, 1'b0, 32'h10, 32'h8899_7FBB);
    flt(1'b0, 2'd2, 32'h3000, 2'd2);
    ld(2'd2, 1'b0, 32'h10, 32'h8899_7FBB);
    flt(1'b1, 2'd3, 32'h10, 2'd3);
    ld(2'd2, 1'b0, 32'h10, 32'h8899_7FBB);
    flt(1'b0, 2'd3, 32'h3003, 2'd3);
    flt(1'b0, 2'd2, 32'h3002, 2'd1);
    flt(1'b1, 2'd0, 32'hFFFF_FFFF, 2'd2);
    st(2'd2, 32'h2FFC, 32'hDEAD_BEEF);
    ld(2'd2, 1'b0, 32'h2FFC, 32'hDEAD_BEEF);
    drain();
    check("exc_code_hold", 32'(exc_code), 32'd2);
    check("rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // 4. back-to-back store then load to the same word
    send(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'd0, c1);
    send(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, c2);
    check("b2b_gap", 32'(c2 - c1), 32'd1);
    drain();

    // 5. clr_start together with a load
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1, 1'b0, 32'h8899_7FBB, c1);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("clr_busy_len", 32'(n), 32'(DEPTH));
    check("clr_ready", 32'(req_ready), 32'd1);
    ld(2'd2, 1'b0, 32'h10, 32'h0000_0000);
    ld(2'd2, 1'b0, 32'h2FFC, 32'h0000_0000);
    flt(1'b1, 2'd3, 32'h0, 2'd3);
    drain();

    // 6. reset in the middle of a sweep restarts it
    @(negedge clk) clr_start = 1'b1;
    @(negedge clk) clr_start = 1'b0;
    check("clr_only_busy", 32'(busy), 32'd1);
    repeat (999) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_exc_code", 32'(exc_code), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    n = 0;
    while (!req_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("restart_len", 32'(n), 32'(DEPTH));
    ld(2'd0, 1'b0, 32'h2FFF, 32'h0000_0000);
    drain();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
